// File: rtl/add_issue_stage.sv
// Generic synchronous FIFO with an extra pointer bit to tell full from empty.
// Latency: a pushed entry is visible at pop_dat the cycle after the push edge.
// Backpressure: push_rdy drops when full (no pop lookahead); pop_rdy is ignored when empty.
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    output logic          push_rdy,
    input  logic [DW-1:0] push_dat,
    output logic          pop_vld,
    input  logic          pop_rdy,
    output logic [DW-1:0] pop_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic          full, empty;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_rdy = !full;
    assign pop_vld  = !empty;
    assign pop_dat  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_vld && !full) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_rdy && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// Issue/retire stage around an external adder: FIFO-buffered operands, registered sum + {V,N,Z,C}, running accumulator.
// Latency: 2 edges from input accept to out_valid when the output register is free; 1 result/cycle sustained.
// Backpressure: out_valid & !out_ready freezes the result and stalls the FIFO; in_ready = FIFO not full.
module add_issue_stage #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [3:0]       out_flags,
    output logic [WIDTH-1:0] acc_q
);
    typedef struct packed {
        logic             acc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } entry_t;

    localparam int EW = $bits(entry_t);

    entry_t           in_ent, head;
    logic [EW-1:0]    head_dat;
    logic             head_vld;
    logic             xfer;
    logic             flag_v, flag_n, flag_z;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic [3:0]       out_flags_q, out_flags_d;
    logic [WIDTH-1:0] acc_d;

    assign in_ent = '{acc: in_acc, a: in_a, b: in_b};
    assign head   = entry_t'(head_dat);

    sync_fifo #(.DW(EW), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (in_ent),
        .pop_vld  (head_vld),
        .pop_rdy  (xfer),
        .pop_dat  (head_dat)
    );

    // Accumulator substitution happens at issue, so chained ops see the sum of the previous transfer.
    assign add_a = !head_vld ? '0 : (head.acc ? acc_q : head.a);
    assign add_b = head_vld ? head.b : '0;

    assign xfer   = head_vld && (!out_valid_q || out_ready);
    assign flag_v = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
    assign flag_n = add_sum[WIDTH-1];
    assign flag_z = (add_sum == '0);

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_flags_d = out_flags_q;
        acc_d       = acc_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_sum_d   = add_sum;
            out_flags_d = {flag_v, flag_n, flag_z, add_carry};
            acc_d       = add_sum;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // Clear overrides the transfer's accumulator update.
        if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_flags_q <= '0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_flags_q <= out_flags_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_flags = out_flags_q;
endmodule

// File: tb/tb_add_issue_stage.sv
// Bench for add_issue_stage: directed scenarios plus random traffic against a queue-based reference model.
module tb_add_issue_stage;
    logic       clk, rst;
    logic       in_valid, in_ready, in_acc, acc_clr;
    logic [7:0] in_a, in_b;
    logic [7:0] add_a, add_b, add_sum;
    logic       add_carry;
    logic       out_valid, out_ready;
    logic [7:0] out_sum, acc_q;
    logic [3:0] out_flags;
    logic [8:0] sum9;

    int n_vec = 0;
    int n_err = 0;

    add_issue_stage #(.DEPTH(2), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clr(acc_clr),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_carry(add_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_flags(out_flags), .acc_q(acc_q)
    );

    // External 8-bit adder stand-in.
    assign sum9      = {1'b0, add_a} + {1'b0, add_b};
    assign add_sum   = sum9[7:0];
    assign add_carry = sum9[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        bit acc;
    } ent_t;

    ent_t q[$];
    bit   m_ov;
    int   m_sum, m_flags, m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_sum = 0; m_flags = 0; m_acc = 0;
    endtask

    function automatic int exp_add_a();
        if (q.size() == 0) return 0;
        return q[0].acc ? m_acc : q[0].a;
    endfunction

    function automatic int exp_add_b();
        if (q.size() == 0) return 0;
        return q[0].b;
    endfunction

    // One clock edge: advance the model from the pre-edge inputs, then compare.
    task automatic step();
        bit   full, push, t;
        int   a, b, us, ss;
        ent_t e;
        @(posedge clk);
        full = (q.size() == 2);
        push = in_valid && !full;
        t    = (q.size() > 0) && (!m_ov || out_ready);
        if (t) begin
            a  = exp_add_a();
            b  = exp_add_b();
            us = a + b;
            ss = (a > 127 ? a - 256 : a) + (b > 127 ? b - 256 : b);
            m_sum   = us % 256;
            m_flags = ((ss > 127 || ss < -128) ? 8 : 0) + (m_sum >= 128 ? 4 : 0) +
                      (m_sum == 0 ? 2 : 0) + (us > 255 ? 1 : 0);
            m_ov    = 1;
            m_acc   = m_sum;
            void'(q.pop_front());
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (acc_clr) m_acc = 0;
        if (push) begin
            e.a = int'(in_a); e.b = int'(in_b); e.acc = in_acc;
            q.push_back(e);
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("acc_q", 32'(acc_q), 32'(m_acc));
        chk("add_a", 32'(add_a), 32'(exp_add_a()));
        chk("add_b", 32'(add_b), 32'(exp_add_b()));
        chk("out_sum", 32'(out_sum), 32'(m_sum));
        chk("out_flags", 32'(out_flags), 32'(m_flags));
    endtask

    task automatic drive(input bit v, input logic [7:0] a, input logic [7:0] b,
                         input bit acc, input bit clr, input bit ordy);
        in_valid = v; in_a = a; in_b = b; in_acc = acc; acc_clr = clr; out_ready = ordy;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 8'h00, 8'h00, 0, 0, 0);
        model_reset();
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_acc", 32'(acc_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic add
        drive(1, 8'h12, 8'h34, 0, 0, 1); step();
        drive(0, 8'h00, 8'h00, 0, 0, 1); step();
        chk("basic_sum", 32'(out_sum), 32'h46);
        chk("basic_flags", 32'(out_flags), 32'h0);
        step();

        // Carry/zero, then signed overflow
        drive(1, 8'hFF, 8'h01, 0, 0, 1); step();
        drive(1, 8'h7F, 8'h01, 0, 0, 1); step();
        chk("cz_sum", 32'(out_sum), 32'h00);
        chk("cz_flags", 32'(out_flags), 32'b0011);
        drive(0, 8'h00, 8'h00, 0, 0, 1); step();
        chk("ovf_sum", 32'(out_sum), 32'h80);
        chk("ovf_flags", 32'(out_flags), 32'b1100);
        step();

        // Accumulate chain
        drive(0, 8'h00, 8'h00, 0, 1, 1); step();
        drive(1, 8'h05, 8'h03, 0, 0, 1); step();
        drive(1, 8'hAA, 8'h0A, 1, 0, 1); step();
        chk("chain0", 32'(out_sum), 32'h08);
        drive(1, 8'h55, 8'h14, 1, 0, 1); step();
        chk("chain1", 32'(out_sum), 32'h12);
        drive(0, 8'h00, 8'h00, 0, 0, 1); step();
        chk("chain2", 32'(out_sum), 32'h26);
        chk("chain_acc", 32'(acc_q), 32'h26);
        step();

        // Backpressure and full FIFO
        drive(1, 8'h01, 8'h01, 0, 0, 0); step();
        drive(1, 8'h02, 8'h02, 0, 0, 0); step();
        drive(1, 8'h03, 8'h03, 0, 0, 0); step();
        chk("bp_full", 32'(in_ready), 32'd0);
        drive(1, 8'h04, 8'h04, 0, 0, 0); step(); step();
        chk("bp_hold_sum", 32'(out_sum), 32'h02);
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        drive(1, 8'h04, 8'h04, 0, 0, 1); step();
        chk("bp_r2", 32'(out_sum), 32'h04);
        step();
        chk("bp_r3", 32'(out_sum), 32'h06);
        drive(0, 8'h00, 8'h00, 0, 0, 1); step();
        chk("bp_r4", 32'(out_sum), 32'h08);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Clear colliding with an accumulator transfer
        drive(0, 8'h00, 8'h00, 0, 1, 1); step();
        drive(1, 8'h10, 8'h00, 0, 0, 1); step();
        drive(0, 8'h00, 8'h00, 0, 0, 1); step();
        chk("cc_acc10", 32'(acc_q), 32'h10);
        drive(1, 8'h77, 8'h01, 1, 0, 1); step();
        drive(0, 8'h00, 8'h00, 0, 1, 1); step();
        chk("cc_sum", 32'(out_sum), 32'h11);
        chk("cc_acc", 32'(acc_q), 32'h00);
        drive(0, 8'h00, 8'h00, 0, 0, 1); step();

        // Async reset mid-stream
        drive(1, 8'h21, 8'h03, 0, 0, 0); step();
        drive(1, 8'h22, 8'h04, 0, 0, 0); step();
        drive(1, 8'h23, 8'h05, 0, 0, 0); step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(out_sum), 32'd0);
        chk("mid_rst_acc", 32'(acc_q), 32'd0);
        model_reset();
        drive(0, 8'h00, 8'h00, 0, 0, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 32'(in_ready), 32'd1);
        step(); step();
        chk("post_rst_stale", 32'(out_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0);
            step();
        end
        drive(0, 8'h00, 8'h00, 0, 0, 1);
        step(); step(); step();
        chk("final_drain", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
